id_ex_alu_issue: RTL and testbench
==================================

// Module: id_ex_alu_issue
// PURPOSE
//  Decode-to-execute issue stage for the RV32I 5-stage pipeline. Consumes the decoded
//  instruction word, PC and register-file read data in D, then generates the immediate.
//  Produces the 5-bit ALU opcode and selects operands A/B. Holds everything in the ID/EX
//  pipeline register that directly drives the execute-stage ALU (alu_opE, SrcAE, SrcBE).
// PARAMETERS
//  XLEN       32       datapath width; only 32 is supported
//  BUBBLE_OP  5'b00000 alu_opE value driven for bubbles/reset (ADD)
// PORTS
//  clk         in   1     rising-edge clock
//  rst         in   1     asynchronous, active-low reset
//  instrD      in   32    instruction in decode
//  PCD         in   32    PC of instrD
//  validD      in   1     instrD is a real instruction
//  rs1_dataD   in   32    register-file read port 1
//  rs2_dataD   in   32    register-file read port 2
//  StallE      in   1     hold ID/EX register contents
//  FlushE      in   1     insert bubble into E (overrides StallE)
//  alu_opE     out  5     ALU opcode: 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASSB
//  SrcAE       out  32    ALU operand A
//  SrcBE       out  32    ALU operand B
//  rdE         out  5     destination register (instr[11:7]); 0 for stores and branches
//  validE      out  1     E-stage slot holds a real instruction
//  illegalE    out  1     opcode/funct not RV32I-ALU-decodable
// BEHAVIOUR
//  - Reset (rst=0, async): alu_opE=BUBBLE_OP, SrcAE=SrcBE=0, rdE=0, validE=0, illegalE=0.
//  - Latency: 1 cycle, D-stage inputs at edge N appear on the E outputs after edge N.
//  - Priority at each edge: FlushE > StallE > load.
//    - Flush: load the reset values (a bubble).
//    - Stall: hold all outputs.
//    - Load: capture the decode of the D-stage inputs.
//  - validD=0 with no flush/stall: load a bubble (validE=0, alu_opE=BUBBLE_OP, operands 0).
//  - Opcode decode (instr[6:0]):
//    - 0110011 R-type: f3 000 -> ADD, or SUB if instr[30]; 001 SLL; 010 SLT; 011 SLTU;
//      100 XOR; 101 -> SRL, or SRA if instr[30]; 110 OR; 111 AND. A=rs1, B=rs2.
//      funct7 other than 0000000/0100000, or instr[30] set with f3 not in {000,101} -> illegal.
//    - 0010011 I-ALU: same mapping, except f3 000 is always ADD. A=rs1, B=sext(I-imm).
//      Shift-immediates (f3 001/101): B={27'b0,instr[24:20]}, SRA if instr[30].
//      SLLI with instr[31:25]!=0 is illegal.
//    - 0110111 LUI: PASSB, A=0, B={instr[31:12],12'b0}.
//    - 0010111 AUIPC: ADD, A=PC, B=U-imm.
//    - 0000011 load: ADD, A=rs1, B=sext(I-imm).
//    - 0100011 store: ADD, A=rs1, B=sext(S-imm), rdE=0.
//    - 1101111 JAL / 1100111 JALR: ADD, A=PC, B=4 (link value).
//    - 1100011 branch: SUB, A=rs1, B=rs2, rdE=0.
//    - Any other opcode: illegal=1, alu_opE=ADD, operands 0, rdE=0, validE still =validD.
//  - All arithmetic wraps mod 2^32; immediates are sign-extended from bit 31 of instrD.
//  - Reset asserted mid-stall or mid-flush: outputs go to reset values immediately.
//    The first load after release captures the current D-stage inputs.
// TESTING
//  1. Reset low for 2 cycles -> all outputs 0, validE=0. Release rst with validD=0
//     -> outputs stay 0.
//  2. instrD=0x40B50533 (sub x10,x10,x11), rs1=5, rs2=7 -> next cycle:
//     alu_opE=1, SrcAE=5, SrcBE=7, rdE=10, validE=1.
//  3. instrD=0x40335293 (srai x5,x6,3), rs1=0x80000000 -> alu_opE=7, SrcBE=0x00000003.
//     instrD=0x123450B7 (lui) -> alu_opE=10, SrcBE=0x12345000.
//  4. Load add, then StallE=1 for 3 cycles while instrD changes -> outputs frozen.
//     StallE=1 together with FlushE=1 -> bubble on the next cycle.
//  5. instrD=0x0000007F, validD=1 -> illegalE=1, alu_opE=0, validE=1, rdE=0.
//     Next instruction valid -> illegalE=0.
//  6. JAL with PCD=0xFFFFFFFC -> alu_opE=0, SrcAE=0xFFFFFFFC, SrcBE=4 (the ALU sum wraps to 0).
//     Pull rst low mid-stream -> reset values asynchronously, before the next edge.

Source files
------------

// File: rtl/id_ex_alu_issue.sv
// RV32I decode-to-execute issue stage: decodes the D-stage instruction into an ALU opcode
// and operands, and registers them in the ID/EX pipeline register that feeds the ALU.
module id_ex_alu_issue #(
  parameter int         XLEN      = 32,
  parameter logic [4:0] BUBBLE_OP = 5'b00000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instrD,
  input  logic [XLEN-1:0] PCD,
  input  logic            validD,
  input  logic [XLEN-1:0] rs1_dataD,
  input  logic [XLEN-1:0] rs2_dataD,
  input  logic            StallE,
  input  logic            FlushE,
  output logic [4:0]      alu_opE,
  output logic [XLEN-1:0] SrcAE,
  output logic [XLEN-1:0] SrcBE,
  output logic [4:0]      rdE,
  output logic            validE,
  output logic            illegalE
);

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [31:0]     imm_i;
  logic [31:0]     imm_s;
  logic [31:0]     imm_u;
  logic [31:0]     shamt;

  logic [4:0]      dec_op;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [4:0]      dec_rd;
  logic            dec_ill;

  assign opcode = instrD[6:0];
  assign funct3 = instrD[14:12];
  assign funct7 = instrD[31:25];
  assign imm_i  = {{20{instrD[31]}}, instrD[31:20]};
  assign imm_s  = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
  assign imm_u  = {instrD[31:12], 12'b0};
  assign shamt  = {27'b0, instrD[24:20]};

  // funct3 to ALU opcode; alt selects SUB/SRA where the encoding allows it
  function automatic logic [4:0] f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec_op  = ALU_ADD;
    dec_a   = '0;
    dec_b   = '0;
    dec_rd  = instrD[11:7];
    dec_ill = 1'b0;
    case (opcode)
      OP_R: begin
        dec_op = f3_op(funct3, instrD[30]);
        dec_a  = rs1_dataD;
        dec_b  = rs2_dataD;
        if (!((funct7 == 7'b0000000) ||
              ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
          dec_ill = 1'b1;
      end
      OP_I: begin
        dec_op = f3_op(funct3, (funct3 == 3'b101) && instrD[30]);
        dec_a  = rs1_dataD;
        dec_b  = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? shamt : imm_i;
        if ((funct3 == 3'b001) && (funct7 != 7'b0000000))
          dec_ill = 1'b1;
      end
      OP_LUI: begin
        dec_op = ALU_PASSB;
        dec_b  = imm_u;
      end
      OP_AUIPC: begin
        dec_a = PCD;
        dec_b = imm_u;
      end
      OP_LOAD: begin
        dec_a = rs1_dataD;
        dec_b = imm_i;
      end
      OP_STORE: begin
        dec_a  = rs1_dataD;
        dec_b  = imm_s;
        dec_rd = 5'd0;
      end
      OP_JAL, OP_JALR: begin
        dec_a = PCD;
        dec_b = 32'd4;
      end
      OP_BRANCH: begin
        dec_op = ALU_SUB;
        dec_a  = rs1_dataD;
        dec_b  = rs2_dataD;
        dec_rd = 5'd0;
      end
      default: dec_ill = 1'b1;
    endcase
    // Undecodable instructions still occupy the slot but present a harmless ADD 0+0
    if (dec_ill) begin
      dec_op = ALU_ADD;
      dec_a  = '0;
      dec_b  = '0;
      dec_rd = 5'd0;
    end
  end

  // ID/EX register: flush beats stall; an invalid D slot becomes a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_opE  <= BUBBLE_OP;
      SrcAE    <= '0;
      SrcBE    <= '0;
      rdE      <= 5'd0;
      validE   <= 1'b0;
      illegalE <= 1'b0;
    end else if (FlushE || (!StallE && !validD)) begin
      alu_opE  <= BUBBLE_OP;
      SrcAE    <= '0;
      SrcBE    <= '0;
      rdE      <= 5'd0;
      validE   <= 1'b0;
      illegalE <= 1'b0;
    end else if (!StallE) begin
      alu_opE  <= dec_op;
      SrcAE    <= dec_a;
      SrcBE    <= dec_b;
      rdE      <= dec_rd;
      validE   <= 1'b1;
      illegalE <= dec_ill;
    end
  end

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed, table-driven bench for id_ex_alu_issue with hand sequences for stall,
// flush, illegal recovery, PC wrap and asynchronous reset.
module tb_id_ex_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrD;
  logic [31:0] PCD;
  logic        validD;
  logic [31:0] rs1_dataD;
  logic [31:0] rs2_dataD;
  logic        StallE;
  logic        FlushE;
  logic [4:0]  alu_opE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic [4:0]  rdE;
  logic        validE;
  logic        illegalE;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        vld;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ve;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  id_ex_alu_issue dut (
    .clk       (clk),
    .rst       (rst),
    .instrD    (instrD),
    .PCD       (PCD),
    .validD    (validD),
    .rs1_dataD (rs1_dataD),
    .rs2_dataD (rs2_dataD),
    .StallE    (StallE),
    .FlushE    (FlushE),
    .alu_opE   (alu_opE),
    .SrcAE     (SrcAE),
    .SrcBE     (SrcBE),
    .rdE       (rdE),
    .validE    (validE),
    .illegalE  (illegalE)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic vld, input logic stall, input logic flush);
    instrD    = instr;
    PCD       = pc;
    rs1_dataD = r1;
    rs2_dataD = r2;
    validD    = vld;
    StallE    = stall;
    FlushE    = flush;
  endtask

  task automatic checkOutput(input string name, input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd, input logic ve,
                             input logic ill);
    total++;
    if ({alu_opE, SrcAE, SrcBE, rdE, validE, illegalE} !== {op, a, b, rd, ve, ill}) begin
      bad++;
      $display("[TB] FAIL %s: got op=%0d a=%h b=%h rd=%0d v=%b ill=%b, want op=%0d a=%h b=%h rd=%0d v=%b ill=%b",
               name, alu_opE, SrcAE, SrcBE, rdE, validE, illegalE, op, a, b, rd, ve, ill);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs.push_back('{"sub",       32'h40B50533, 32'h00001000, 32'd5,        32'd7,        1'b1, 5'd1,  32'd5,        32'd7,        5'd10, 1'b1, 1'b0});
    vecs.push_back('{"srai",      32'h40335293, 32'h00001004, 32'h80000000, 32'h0,        1'b1, 5'd7,  32'h80000000, 32'h00000003, 5'd5,  1'b1, 1'b0});
    vecs.push_back('{"lui",       32'h123450B7, 32'h00001008, 32'hDEADBEEF, 32'h1,        1'b1, 5'd10, 32'h0,        32'h12345000, 5'd1,  1'b1, 1'b0});
    vecs.push_back('{"addi_neg",  32'hFFF00093, 32'h0000100C, 32'h0,        32'h9,        1'b1, 5'd0,  32'h0,        32'hFFFFFFFF, 5'd1,  1'b1, 1'b0});
    vecs.push_back('{"auipc",     32'h80000297, 32'h00002000, 32'h11,       32'h22,       1'b1, 5'd0,  32'h00002000, 32'h80000000, 5'd5,  1'b1, 1'b0});
    vecs.push_back('{"lw",        32'hFFC3A303, 32'h00002004, 32'h00000100, 32'h0,        1'b1, 5'd0,  32'h00000100, 32'hFFFFFFFC, 5'd6,  1'b1, 1'b0});
    vecs.push_back('{"sw_neg",    32'hFE20AC23, 32'h00002008, 32'h00000200, 32'h33,       1'b1, 5'd0,  32'h00000200, 32'hFFFFFFF8, 5'd0,  1'b1, 1'b0});
    vecs.push_back('{"beq",       32'h00208463, 32'h0000200C, 32'd40,       32'd41,       1'b1, 5'd1,  32'd40,       32'd41,       5'd0,  1'b1, 1'b0});
    vecs.push_back('{"jal",       32'h008000EF, 32'h00003000, 32'h5,        32'h6,        1'b1, 5'd0,  32'h00003000, 32'd4,        5'd1,  1'b1, 1'b0});
    vecs.push_back('{"jalr",      32'h00008067, 32'h00003004, 32'h5,        32'h6,        1'b1, 5'd0,  32'h00003004, 32'd4,        5'd0,  1'b1, 1'b0});
    vecs.push_back('{"sll",       32'h003110B3, 32'h00003008, 32'hA,        32'hB,        1'b1, 5'd2,  32'hA,        32'hB,        5'd1,  1'b1, 1'b0});
    vecs.push_back('{"sltu",      32'h0062B233, 32'h0000300C, 32'h1,        32'hFFFFFFFF, 1'b1, 5'd4,  32'h1,        32'hFFFFFFFF, 5'd4,  1'b1, 1'b0});
    vecs.push_back('{"andi",      32'h0F047393, 32'h00003010, 32'h12345678, 32'h0,        1'b1, 5'd9,  32'h12345678, 32'h000000F0, 5'd7,  1'b1, 1'b0});
    vecs.push_back('{"xori_min",  32'h8000C093, 32'h00003014, 32'h7,        32'h0,        1'b1, 5'd5,  32'h7,        32'hFFFFF800, 5'd1,  1'b1, 1'b0});
    vecs.push_back('{"slli_bad",  32'h40209093, 32'h00003018, 32'h7,        32'h8,        1'b1, 5'd0,  32'h0,        32'h0,        5'd0,  1'b1, 1'b1});
    vecs.push_back('{"or_alt",    32'h4020E0B3, 32'h0000301C, 32'h7,        32'h8,        1'b1, 5'd0,  32'h0,        32'h0,        5'd0,  1'b1, 1'b1});
    vecs.push_back('{"mul_f7",    32'h022080B3, 32'h00003020, 32'h7,        32'h8,        1'b1, 5'd0,  32'h0,        32'h0,        5'd0,  1'b1, 1'b1});
    vecs.push_back('{"invalid_d", 32'h40B50533, 32'h00003024, 32'd5,        32'd7,        1'b0, 5'd0,  32'h0,        32'h0,        5'd0,  1'b0, 1'b0});

    rst = 1'b0;
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    checkOutput("reset", 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    checkOutput("idle_after_reset", 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].vld, 1'b0, 1'b0);
      step();
      checkOutput(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].ve, vecs[i].ill);
    end

    // Stall holds the add while D-stage inputs keep changing
    applyStimulus(32'h002081B3, 32'h00004000, 32'd11, 32'd22, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("add_before_stall", 5'd0, 32'd11, 32'd22, 5'd3, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(32'h40B50533 + k, 32'h00004004, 32'd100 + k, 32'd200 + k, 1'b1, 1'b1, 1'b0);
      step();
      checkOutput($sformatf("stall_hold_%0d", k), 5'd0, 32'd11, 32'd22, 5'd3, 1'b1, 1'b0);
    end
    applyStimulus(32'h40B50533, 32'h00004008, 32'd1, 32'd2, 1'b1, 1'b1, 1'b1);
    step();
    checkOutput("stall_and_flush", 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

    // Illegal opcode still occupies a valid slot; the next instruction clears the flag
    applyStimulus(32'h0000007F, 32'h00005000, 32'h55, 32'h66, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("illegal_opcode", 5'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1);
    applyStimulus(32'h002081B3, 32'h00005004, 32'h55, 32'h66, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("legal_after_illegal", 5'd0, 32'h55, 32'h66, 5'd3, 1'b1, 1'b0);

    // JAL at the top of the address space, then an asynchronous reset mid-cycle
    applyStimulus(32'h008000EF, 32'hFFFFFFFC, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("jal_pc_wrap", 5'd0, 32'hFFFFFFFC, 32'd4, 5'd1, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_reset", 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    step();
    checkOutput("reset_held_over_edge", 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(32'h0F047393, 32'h00006000, 32'hCAFE0000, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("load_after_reset", 5'd9, 32'hCAFE0000, 32'h000000F0, 5'd7, 1'b1, 1'b0);

    // Reset during a stall clears the frozen contents; release resumes loading
    applyStimulus(32'h40B50533, 32'h00006004, 32'd9, 32'd4, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    checkOutput("reset_mid_stall", 5'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    StallE = 1'b0;
    step();
    checkOutput("first_load_after_stall_reset", 5'd1, 32'd9, 32'd4, 5'd10, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
